// File: rtl/hw2_prob2_sweeper_pkg.sv
// Shared types and widths for the hw2_prob2 exhaustive-stimulus sweeper.
// Pattern order is {enableN, in1..in5}. All 32 enabled codes come first.
package hw2_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int PAT_W   = 6;
    localparam int RESP_W  = 32;
    localparam int CNT_W   = 6;
    localparam int DWELL_W = 8;

    localparam logic [PAT_W-1:0] PAT_LAST = 6'd63;

endpackage

// File: rtl/hw2_prob2_sweeper_if.sv
// Stimulus, response and result bundle between the sweeper and its host/DUT side.
// master = sweeper, slave = host driving start and the circuit returning resp.
interface hw2_prob2_sweeper_if;

    logic                              start;
    logic                              enableN;
    logic                              in1;
    logic                              in2;
    logic                              in3;
    logic                              in4;
    logic                              in5;
    logic                              resp;
    logic                              busy;
    logic                              done;
    logic [hw2_sweep_pkg::RESP_W-1:0]  resp_vec;
    logic [hw2_sweep_pkg::CNT_W-1:0]   ones_count;

    modport master (
        input  start, resp,
        output enableN, in1, in2, in3, in4, in5, busy, done, resp_vec, ones_count
    );

    modport slave (
        output start, resp,
        input  enableN, in1, in2, in3, in4, in5, busy, done, resp_vec, ones_count
    );

endinterface

// File: rtl/hw2_prob2_sweeper_dwell_counter.sv
// Loadable down-counter that paces how long each pattern is held.
// Latency: load/decrement take effect at the next edge; zero is combinational from the count.
// Backpressure: none; it stops at zero until reloaded.
module dwell_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/hw2_prob2_sweeper.sv
// Walks all 64 {enableN,in1..in5} codes and holds each for DWELL cycles. It captures resp on enabled codes.
// Latency: pattern 0 appears one edge after start. done rises 64*DWELL+1 edges after the start edge.
// Backpressure: none; start is only honoured in IDLE and is never queued.
module hw2_prob2_sweeper
    import hw2_sweep_pkg::*;
#(
    parameter int DWELL = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    hw2_prob2_sweeper_if.master bus
);

    localparam logic [DWELL_W-1:0] RELOAD = DWELL_W'(DWELL - 1);

    state_t              state, state_nx;
    logic [PAT_W-1:0]    pat, pat_nx;
    logic [RESP_W-1:0]   vec, vec_nx;
    logic [CNT_W-1:0]    ones, ones_nx;
    logic                done_q, done_nx;
    logic                cnt_load;
    logic                cnt_zero;
    logic                running;

    assign running = (state == RUN);

    dwell_counter #(
        .W (DWELL_W)
    ) u_dwell (
        .clk      (clk),
        .rst_n    (reset_n),
        .load     (cnt_load),
        .load_val (RELOAD),
        .dec      (running),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            pat    <= '0;
            vec    <= '0;
            ones   <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            pat    <= pat_nx;
            vec    <= vec_nx;
            ones   <= ones_nx;
            done_q <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pat_nx   = pat;
        vec_nx   = vec;
        ones_nx  = ones;
        done_nx  = 1'b0;
        cnt_load = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    vec_nx   = '0;
                    ones_nx  = '0;
                    pat_nx   = '0;
                    cnt_load = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (cnt_zero) begin
                    if (!pat[PAT_W-1]) begin
                        vec_nx[pat[4:0]] = bus.resp;
                        ones_nx          = ones + CNT_W'(bus.resp);
                    end
                    if (pat == PAT_LAST) begin
                        state_nx = DONE;
                    end else begin
                        pat_nx   = pat + 1'b1;
                        cnt_load = 1'b1;
                    end
                end
            end
            DONE: begin
                // First DONE cycle launches the pulse; the pulse cycle itself returns to IDLE.
                if (!done_q) begin
                    done_nx = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign bus.enableN    = running ? pat[5] : 1'b1;
    assign {bus.in1, bus.in2, bus.in3, bus.in4, bus.in5} = running ? pat[4:0] : 5'b0;
    assign bus.busy       = running || ((state == DONE) && !done_q);
    assign bus.done       = done_q;
    assign bus.resp_vec   = vec;
    assign bus.ones_count = ones;

endmodule

// File: tb/tb_hw2_prob2_sweeper.sv
// Bench for hw2_prob2_sweeper: three instances (DWELL 5, 3, 1) sharing clock and reset.
// Each sweep queues the expected per-cycle pattern and scores results against a model of the circuit.
module tb_hw2_prob2_sweeper;

    logic        clk;
    logic        reset_n;
    logic [2:0]  start_a;
    logic        flip;

    logic [5:0]  pat_o  [3];
    logic [2:0]  busy_o;
    logic [2:0]  done_o;
    logic [31:0] vec_o  [3];
    logic [5:0]  ones_o [3];

    int tests = 0;
    int fails = 0;

    hw2_prob2_sweeper_if bus5 ();
    hw2_prob2_sweeper_if bus3 ();
    hw2_prob2_sweeper_if bus1 ();

    hw2_prob2_sweeper #(.DWELL(5)) u_d5 (.clk(clk), .reset_n(reset_n), .bus(bus5));
    hw2_prob2_sweeper #(.DWELL(3)) u_d3 (.clk(clk), .reset_n(reset_n), .bus(bus3));
    hw2_prob2_sweeper #(.DWELL(1)) u_d1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

    // Circuit models: k0 = in1&in5 (optionally inverted), k1 = in2^in4 with 1 when disabled, k2 = tied 1.
    assign bus5.start = start_a[0];
    assign bus3.start = start_a[1];
    assign bus1.start = start_a[2];
    assign bus5.resp  = (bus5.in1 & bus5.in5) ^ flip;
    assign bus3.resp  = bus3.enableN ? 1'b1 : (bus3.in2 ^ bus3.in4);
    assign bus1.resp  = 1'b1;

    assign pat_o[0]  = {bus5.enableN, bus5.in1, bus5.in2, bus5.in3, bus5.in4, bus5.in5};
    assign pat_o[1]  = {bus3.enableN, bus3.in1, bus3.in2, bus3.in3, bus3.in4, bus3.in5};
    assign pat_o[2]  = {bus1.enableN, bus1.in1, bus1.in2, bus1.in3, bus1.in4, bus1.in5};
    assign busy_o    = {bus1.busy, bus3.busy, bus5.busy};
    assign done_o    = {bus1.done, bus3.done, bus5.done};
    assign vec_o[0]  = bus5.resp_vec;
    assign vec_o[1]  = bus3.resp_vec;
    assign vec_o[2]  = bus1.resp_vec;
    assign ones_o[0] = bus5.ones_count;
    assign ones_o[1] = bus3.ones_count;
    assign ones_o[2] = bus1.ones_count;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dw(input int k);
        case (k)
            0:       return 5;
            1:       return 3;
            default: return 1;
        endcase
    endfunction

    function automatic bit model(input int k, input int p);
        logic [5:0] pv;
        pv = 6'(p);
        case (k)
            0:       return (pv[4] & pv[0]) ^ flip;
            1:       return pv[3] ^ pv[1];
            default: return 1'b1;
        endcase
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        start_a = 3'b000;
        flip    = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            tests++;
            if (busy_o !== 3'b000 || done_o !== 3'b000) begin
                fails++;
                $display("FAIL reset_idle_flags cyc %0d: busy=%b done=%b want 000/000", n, busy_o, done_o);
            end
        end
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (pat_o[k] !== 6'h20) begin
                fails++;
                $display("FAIL reset_pattern k%0d: got %h want 20", k, pat_o[k]);
            end
            tests++;
            if (vec_o[k] !== 32'h0 || ones_o[k] !== 6'd0) begin
                fails++;
                $display("FAIL reset_results k%0d: vec=%h ones=%0d want 0/0", k, vec_o[k], ones_o[k]);
            end
        end
    endtask

    task automatic run_sweep(input int k, input bit poke, input string tag);
        logic [5:0]  exp_q [$];
        logic [5:0]  ep;
        logic [31:0] ev;
        logic [5:0]  eo;
        int          dwell;
        int          done_cnt;
        int          done_at;
        dwell = dw(k);
        ev = '0;
        eo = '0;
        for (int p = 0; p < 32; p++) begin
            if (model(k, p)) begin
                ev[p] = 1'b1;
                eo    = eo + 6'd1;
            end
        end
        @(negedge clk);
        start_a[k] = 1'b1;
        for (int p = 0; p < 64; p++)
            for (int d = 0; d < dwell; d++)
                exp_q.push_back(6'(p));
        done_cnt = 0;
        done_at  = -1;
        for (int n = 0; n < 64 * dwell + 8; n++) begin
            @(negedge clk);
            start_a[k] = 1'b0;
            if (exp_q.size() > 0) begin
                ep = exp_q.pop_front();
                tests++;
                if (pat_o[k] !== ep) begin
                    fails++;
                    $display("FAIL %s pattern cyc %0d: got %h want %h", tag, n, pat_o[k], ep);
                end
                tests++;
                if (busy_o[k] !== 1'b1 || done_o[k] !== 1'b0) begin
                    fails++;
                    $display("FAIL %s run_flags cyc %0d: busy=%b done=%b want 1/0", tag, n, busy_o[k], done_o[k]);
                end
            end else begin
                tests++;
                if (pat_o[k] !== 6'h20) begin
                    fails++;
                    $display("FAIL %s idle_pattern cyc %0d: got %h want 20", tag, n, pat_o[k]);
                end
            end
            if (done_o[k] === 1'b1) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = n;
                    tests++;
                    if (vec_o[k] !== ev || ones_o[k] !== eo || busy_o[k] !== 1'b0) begin
                        fails++;
                        $display("FAIL %s done_results: vec=%h ones=%0d busy=%b want %h/%0d/0",
                                 tag, vec_o[k], ones_o[k], busy_o[k], ev, eo);
                    end
                end
            end
            if (poke && (n == 10 * dwell || n == done_at)) start_a[k] = 1'b1;
        end
        start_a[k] = 1'b0;
        tests++;
        if (done_at != 64 * dwell + 1) begin
            fails++;
            $display("FAIL %s done_latency: got %0d want %0d", tag, done_at, 64 * dwell + 1);
        end
        tests++;
        if (done_cnt != 1) begin
            fails++;
            $display("FAIL %s done_pulses: got %0d want 1", tag, done_cnt);
        end
        tests++;
        if (busy_o[k] !== 1'b0 || vec_o[k] !== ev || ones_o[k] !== eo) begin
            fails++;
            $display("FAIL %s held_results: busy=%b vec=%h ones=%0d want 0/%h/%0d",
                     tag, busy_o[k], vec_o[k], ones_o[k], ev, eo);
        end
    endtask

    task automatic test_full_sweep();
        flip = 1'b0;
        run_sweep(0, 1'b0, "full_d5");
        tests++;
        if (vec_o[0] !== 32'hAAAA_0000 || ones_o[0] !== 6'd8) begin
            fails++;
            $display("FAIL full_d5_literal: vec=%h ones=%0d want aaaa0000/8", vec_o[0], ones_o[0]);
        end
    endtask

    task automatic test_order_hold();
        run_sweep(1, 1'b0, "order_d3");
    endtask

    task automatic test_dwell_one();
        run_sweep(2, 1'b0, "dwell1");
        tests++;
        if (vec_o[2] !== 32'hFFFF_FFFF || ones_o[2] !== 6'd32) begin
            fails++;
            $display("FAIL dwell1_literal: vec=%h ones=%0d want ffffffff/32", vec_o[2], ones_o[2]);
        end
    endtask

    task automatic test_start_ignored();
        flip = 1'b0;
        run_sweep(0, 1'b1, "start_poke");
        flip = 1'b1;
        run_sweep(0, 1'b0, "rerun");
        tests++;
        if (vec_o[0] !== 32'h5555_FFFF || ones_o[0] !== 6'd24) begin
            fails++;
            $display("FAIL rerun_literal: vec=%h ones=%0d want 5555ffff/24", vec_o[0], ones_o[0]);
        end
    endtask

    task automatic test_reset_mid();
        flip = 1'b0;
        @(negedge clk);
        start_a[0] = 1'b1;
        @(negedge clk);
        start_a[0] = 1'b0;
        repeat (100) @(negedge clk);
        tests++;
        if (pat_o[0] !== 6'd20 || vec_o[0] === 32'h0) begin
            fails++;
            $display("FAIL mid_pre_reset: pat=%h vec=%h want 14 and nonzero", pat_o[0], vec_o[0]);
        end
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if (pat_o[0] !== 6'h20 || busy_o[0] !== 1'b0 || done_o[0] !== 1'b0) begin
            fails++;
            $display("FAIL mid_async_outputs: pat=%h busy=%b done=%b want 20/0/0", pat_o[0], busy_o[0], done_o[0]);
        end
        tests++;
        if (vec_o[0] !== 32'h0 || ones_o[0] !== 6'd0) begin
            fails++;
            $display("FAIL mid_async_results: vec=%h ones=%0d want 0/0", vec_o[0], ones_o[0]);
        end
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            tests++;
            if (done_o[0] !== 1'b0 || busy_o[0] !== 1'b0) begin
                fails++;
                $display("FAIL mid_reset_hold cyc %0d: done=%b busy=%b want 0/0", n, done_o[0], busy_o[0]);
            end
        end
        reset_n = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            tests++;
            if (done_o[0] !== 1'b0) begin
                fails++;
                $display("FAIL mid_no_done cyc %0d: done=%b want 0", n, done_o[0]);
            end
        end
        run_sweep(0, 1'b0, "post_reset");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_sweep();
        test_order_hold();
        test_dwell_one();
        test_start_ignored();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hw2_prob2_sweeper.md
# hw2_prob2_sweeper

Hardware exhaustive-stimulus sequencer that sits directly upstream of the `hw2_prob2` combinational/tri-state circuit. On `start`, it walks all 64 combinations of {enableN, in1..in5} in a fixed order and holds each one for a programmable dwell time. It samples the circuit's output on enabled patterns and reports a 32-bit response vector plus a ones count. This replaces the delay-loop stimulus with a synthesizable, clocked sweep usable on the FPGA.

## Interface
- `DWELL`, default 5: clock cycles each pattern is held; legal range 1..255.
- `clk` input 1: rising-edge clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: sweep request, sampled in IDLE only.
- `enableN` output 1: drives DUT `enableN`.
- `in1`..`in5` output 1 each: drive the DUT data inputs.
- `resp` input 1: DUT `tri_outN`; only meaningful while `enableN`=0.
- `busy` output 1: high from start acceptance through the last sample.
- `done` output 1: single-cycle pulse after the sweep completes.
- `resp_vec` output 32: bit [{in1,in2,in3,in4,in5}] = `resp` sampled for that pattern with `enableN`=0.
- `ones_count` output 6: number of 1s in `resp_vec`, range 0..32.

## Operation
- 6-bit pattern counter `pat` maps to outputs as {enableN,in1,in2,in3,in4,in5}. `in5` is the LSB. The count runs 0..63, so all 32 enabled patterns come first, then all 32 disabled patterns.
- FSM has three states: IDLE, RUN, DONE.
  - IDLE: when `start`=1, the block clears `resp_vec`/`ones_count`, sets `pat`=0, loads the dwell counter with DWELL-1, and moves to RUN.
  - RUN: each cycle the dwell counter decrements. At count 0 the block samples the pattern:
    - if pat[5]=0, `resp_vec[pat[4:0]]` ← `resp` and `ones_count` += `resp`;
    - if pat[5]=1, nothing is captured.
    - If `pat`=63, the FSM moves to DONE. Otherwise `pat` increments and the dwell counter reloads.
  - DONE: one cycle with `done`=1, then return to IDLE.
- IDLE/DONE drive levels: `enableN`=1 (DUT output tri-stated) and in1..in5=0.
- `resp_vec` and `ones_count` hold their values after DONE until the next accepted `start`.
- `start` is ignored while in RUN or DONE. It is not queued.
- `ones_count` is 6 bits wide and cannot overflow, because at most 32 increments occur.

## Timing
- Reset values (async, on `reset_n`=0): state=IDLE, `enableN`=1, in1..in5=0, `busy`=0, `done`=0, `resp_vec`=0, `ones_count`=0, `pat`=0.
- `start` high at edge E: at E+1, outputs show pat 0 and `busy`=1.
- Pattern p is driven for exactly DWELL cycles, covering edges E+1+p·DWELL through E+(p+1)·DWELL.
  - Its sample is taken at edge E+(p+1)·DWELL.
  - At that same edge, the outputs change to pattern p+1.
- Results update at the sampling edge. The final `resp_vec` value is valid in the same cycle `done`=1.
- `busy` falls and `done` rises at edge E+64·DWELL+1. `done` is high for exactly one cycle.
- `start` high during the `done` cycle is ignored. `start` in the following IDLE cycle is accepted.
- DWELL=1: the pattern changes every cycle, and the sample is taken in the same edge as the change.
- `reset_n` asserted mid-sweep: immediate abort to reset values, with no `done`. Partial results are discarded.

## Structure
- Package `hw2_sweep_pkg`:
  - `state_t` enum {IDLE, RUN, DONE};
  - constants PAT_W=6, RESP_W=32, CNT_W=6.
- Sub-module `dwell_counter`: loadable down-counter with `load`, `load_val`, `zero` flag and async active-low reset. The FSM, pattern counter and capture logic stay in the top module.
- The DUT is not instantiated inside this block. The block is wired to `hw2_prob2` at the next level.

## Test plan
- Reset-idle check: hold `reset_n`=0, then release with `start`=0 for 20 cycles → `enableN`=1, inputs 0, `busy`=0, `done`=0, `resp_vec`=0.
- Full sweep, DWELL=5, bench model `resp`=in1&in5:
  - `done` pulses exactly 321 cycles after the `start` edge;
  - `resp_vec`=32'hAAAA_0000 and `ones_count`=8.
- Order and hold check, DWELL=3: log outputs each cycle → patterns 0,1,...,63 in order, each held exactly 3 cycles, with `enableN`=0 for the first 96 cycles.
- Boundary, DWELL=1, `resp` tied 1:
  - `resp_vec`=32'hFFFF_FFFF and `ones_count`=32;
  - `done` is high 65 cycles after the `start` edge;
  - `resp` during disabled patterns does not alter the results.
- `start` pulsed during RUN and during the `done` cycle → no restart, `done` pulses exactly once, results unchanged. A second `start` afterwards clears and reruns.
- Assert `reset_n` async, mid-cycle, at pattern 20 → outputs return to reset values without waiting for a clock edge, with no `done` pulse. A new `start` then produces a clean full sweep.
